// File: rtl/cnn_win_pkg.sv
// Shared geometry helpers for the convolution window generator.
// Padding, padded extents, counter widths and flat window indexing.
package cnn_win_pkg;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Zero-padding on each side for "same" output, none for "valid".
    function automatic int pad_of(input int k, input int pad_en);
        return (pad_en != 0) ? (k - 1) / 2 : 0;
    endfunction

    // Padded extent of one image dimension.
    function automatic int padded_dim(input int n, input int k, input int pad_en);
        return n + 2 * pad_of(k, pad_en);
    endfunction

    // Larger of two values, used to size the scan counters.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Flat element index of window element (row i, column j).
    function automatic int idx(input int i, input int j, input int k);
        return i * k + j;
    endfunction

endpackage

// File: rtl/win_line_buf.sv
// One padded-row line buffer: asynchronous read and synchronous write at
// the same address, so a column can be read and overwritten in one advance.
module win_line_buf
    import cnn_win_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 130,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Storage is intentionally not reset; rows are rewritten before use.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Read the old column value while the same advance writes the new one.
    assign rdata_o = mem_q[addr_i];

    // Write the cascaded column value on every scan advance.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// K x K sliding-window generator with internal zero padding and stride.
// Scans the padded frame in raster order and emits one flat window per output.
module conv_window_gen
    import cnn_win_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int PAD_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [K*K*DATA_W-1:0] m_window,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  frame_done
);

    localparam int PN  = pad_of(K, PAD_EN);
    localparam int WP  = padded_dim(IMG_W, K, PAD_EN);
    localparam int HP  = padded_dim(IMG_H, K, PAD_EN);
    localparam int CW  = clog2(max2(WP, HP) + 1);
    localparam int LBW = max2(clog2(WP), 1);
    localparam int LBN = max2(K - 1, 1);
    localparam int KM1 = K - 1;
    // Bottom-right corner of the final window of the frame.
    localparam int LR  = KM1 + ((HP - K) / STRIDE) * STRIDE;
    localparam int LC  = KM1 + ((WP - K) / STRIDE) * STRIDE;

    if (((K % 2) == 0) || (K < 1) || (K > 7)) begin : g_bad_k
        $error("conv_window_gen: K must be odd and within 1..7");
    end
    if ((STRIDE != 1) && (STRIDE != 2)) begin : g_bad_stride
        $error("conv_window_gen: STRIDE must be 1 or 2");
    end
    if ((IMG_W < K) || (IMG_H < K)) begin : g_bad_img
        $error("conv_window_gen: image must be at least K x K");
    end

    logic [CW-1:0]     pr_q, pr_d;
    logic [CW-1:0]     pc_q, pc_d;
    logic              m_valid_q, m_valid_d;
    logic              m_first_q, m_first_d;
    logic              m_last_q, m_last_d;
    logic              done_q, done_d;
    logic              first_pend_q, first_pend_d;
    logic [DATA_W-1:0] win_q [K][K];
    logic [DATA_W-1:0] win_d [K][K];

    logic [DATA_W-1:0] lb_rd [LBN];
    logic [DATA_W-1:0] lb_wd [LBN];
    logic [DATA_W-1:0] col   [K];

    logic [CW-1:0]     row_off, col_off;
    logic [CW-1:0]     row_k, col_k;
    logic              real_pos;
    logic              out_free;
    logic              adv;
    logic              emit;
    logic              row_ok, col_ok;
    logic              at_row_end, at_frame_end;
    logic              is_last_pos;
    logic [DATA_W-1:0] cur;

    // Classify the scan position and decide whether it advances this cycle.
    always_comb begin
        // Offsets wrap to large values above/left of the image, so a
        // single unsigned compare covers both sides of the real region.
        row_off      = pr_q - CW'(PN);
        col_off      = pc_q - CW'(PN);
        real_pos     = (row_off < CW'(IMG_H)) && (col_off < CW'(IMG_W));
        out_free     = !m_valid_q || m_ready;
        adv          = !clr && out_free && (!real_pos || s_valid);
        cur          = real_pos ? s_data : '0;
        // Borrow-free subtraction means the counter has reached K-1.
        row_k        = pr_q - CW'(KM1);
        col_k        = pc_q - CW'(KM1);
        row_ok       = (row_k <= pr_q) && ((STRIDE == 1) || !row_k[0]);
        col_ok       = (col_k <= pc_q) && ((STRIDE == 1) || !col_k[0]);
        emit         = adv && row_ok && col_ok;
        at_row_end   = (pc_q == CW'(WP - 1));
        at_frame_end = at_row_end && (pr_q == CW'(HP - 1));
        is_last_pos  = (pr_q == CW'(LR)) && (pc_q == CW'(LC));
    end

    assign s_ready = real_pos && out_free && !clr && !rst;

    // Assemble the incoming column (oldest row on top) and the cascade data.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            col[i] = '0;
        end
        col[K-1] = cur;
        for (int i = 0; i < K - 1; i++) begin
            col[i] = lb_rd[K-2-i];
        end
        for (int n = 0; n < LBN; n++) begin
            lb_wd[n] = '0;
        end
        lb_wd[0] = cur;
        for (int n = 1; n < LBN; n++) begin
            lb_wd[n] = lb_rd[n-1];
        end
    end

    if (K > 1) begin : g_lines
        for (genvar n = 0; n < K - 1; n++) begin : g_lb
            win_line_buf #(
                .DATA_W (DATA_W),
                .DEPTH  (WP),
                .AW     (LBW)
            ) u_lb (
                .clk     (clk),
                .we_i    (adv),
                .addr_i  (pc_q[LBW-1:0]),
                .wdata_i (lb_wd[n]),
                .rdata_o (lb_rd[n])
            );
        end
    end else begin : g_no_lines
        assign lb_rd[0] = '0;
    end

    // Next-state logic for scan counters, window shift and output flags.
    always_comb begin
        pr_d         = pr_q;
        pc_d         = pc_q;
        m_valid_d    = m_valid_q;
        m_first_d    = m_first_q;
        m_last_d     = m_last_q;
        first_pend_d = first_pend_q;
        done_d       = 1'b0;
        win_d        = win_q;
        if (clr) begin
            pr_d         = '0;
            pc_d         = '0;
            m_valid_d    = 1'b0;
            m_first_d    = 1'b0;
            m_last_d     = 1'b0;
            first_pend_d = 1'b1;
        end else begin
            if (m_ready) begin
                m_valid_d = 1'b0;
            end
            if (adv) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) begin
                        win_d[i][j] = win_q[i][j+1];
                    end
                    win_d[i][K-1] = col[i];
                end
                if (at_row_end) begin
                    pc_d = '0;
                    pr_d = at_frame_end ? '0 : pr_q + CW'(1);
                end else begin
                    pc_d = pc_q + CW'(1);
                end
                if (emit) begin
                    m_valid_d    = 1'b1;
                    m_first_d    = first_pend_q;
                    m_last_d     = is_last_pos;
                    first_pend_d = 1'b0;
                end
                // The next frame starts right after the wrap.
                if (at_frame_end) begin
                    first_pend_d = 1'b1;
                    done_d       = 1'b1;
                end
            end
        end
    end

    // State registers; line buffer contents are deliberately left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr_q         <= '0;
            pc_q         <= '0;
            m_valid_q    <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            done_q       <= 1'b0;
            first_pend_q <= 1'b1;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            pr_q         <= pr_d;
            pc_q         <= pc_d;
            m_valid_q    <= m_valid_d;
            m_first_q    <= m_first_d;
            m_last_q     <= m_last_d;
            done_q       <= done_d;
            first_pend_q <= first_pend_d;
            win_q        <= win_d;
        end
    end

    // The window register only moves on an advance, so it is stable
    // while an emitted window waits for m_ready.
    always_comb begin
        m_window = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                m_window[idx(i, j, K)*DATA_W +: DATA_W] = win_q[i][j];
            end
        end
    end

    assign m_valid    = m_valid_q;
    assign m_first    = m_first_q;
    assign m_last     = m_last_q;
    assign frame_done = done_q;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Parametrised K×K window generator feeding the convolution MAC array; the next generation of the fixed 3×3 line-buffer window.
- Accepts unpadded raster pixels over a valid/ready stream and generates zero-padding internally, so upstream sends only real pixels.
- Supports configurable kernel size, stride, padding on/off and full output backpressure.
- Emits one flat K×K window per output position, with frame-boundary flags.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 128, image width in pixels (≥K)
- IMG_H, 128, image height in pixels (≥K)
- K, 3, kernel size; odd, 1..7
- STRIDE, 1, output stride; 1 or 2
- PAD_EN, 1, 1 = zero padding of P=(K-1)/2 on all sides ("same"); 0 = none ("valid")

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clr  in  1  synchronous frame abort; scan returns to frame start
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&&s_ready
- s_data  in  DATA_W  input pixel, raster order
- m_valid  out  1  window valid
- m_ready  in  1  downstream accepts window
- m_window  out  K*K*DATA_W  window; element (i,j) at bits [(i*K+j)*DATA_W +: DATA_W], i=row, j=col, (0,0)=top-left
- m_first  out  1  with m_valid: first window of frame
- m_last  out  1  with m_valid: last window of frame
- frame_done  out  1  one-cycle pulse after the final scan step of a frame

Behaviour:
- Reset: all outputs are 0 and the scan counters are at padded position (0,0). Line-buffer contents are not reset.
- Padded geometry:
  - PN = PAD_EN ? (K-1)/2 : 0; WP = IMG_W+2*PN; HP = IMG_H+2*PN.
  - Scan counters (pr,pc) walk 0..HP-1 × 0..WP-1 in raster order.
- Position types:
  - Real position: pr in [PN, PN+IMG_H-1] and pc in [PN, PN+IMG_W-1]. Its value is s_data.
  - Any other position is a pad position with value 0, and consumes no input.
- Advance rule:
  - out_free = !m_valid || m_ready.
  - A real position advances only when s_valid && out_free. s_ready = real position && out_free && !clr.
  - A pad position advances whenever out_free; pad positions need no input.
- Window state: K-1 line buffers (depth WP) plus a K×K register window shift one column on every advance.
  - The new column is K-1 line-buffer reads at pc plus the current value.
  - The line buffers are then written cascaded at pc.
- Output emission: on an advance where pr≥K-1, pc≥K-1, (pr-K+1)%STRIDE==0 and (pc-K+1)%STRIDE==0:
  - The next cycle m_valid=1, carrying the window whose bottom-right is (pr,pc).
  - Latency is 1 cycle from the completing advance.
- Output hold: while m_valid && !m_ready, m_window, m_first and m_last stay stable and no advance occurs.
- Output count per frame: ((HP-K)/STRIDE+1)×((WP-K)/STRIDE+1), using floor division.
- Frame flags:
  - m_first marks the first emitted window of the frame; m_last marks the last.
  - frame_done pulses on the cycle after the advance at (HP-1,WP-1).
  - Counters then wrap to (0,0), so frames run back-to-back with no idle cycle.
- Window independence across rows: windows never mix data across frames or across rows; column-shift history is irrelevant because emission requires pc≥K-1.
- clr:
  - Counters return to (0,0) and m_valid clears.
  - clr has priority over any advance in the same cycle; an input beat presented that cycle is not consumed.
- Reset mid-frame: everything returns to the reset state; the next frame starts clean.
- Width rules:
  - Counters are $clog2(max(WP,HP)+1) bits wide.
  - The stride test uses the low bit (STRIDE=2) or is constant true (STRIDE=1).
- Elaboration checks: elaboration fails if K is even, STRIDE∉{1,2}, or IMG_W<K.

Decomposition:
- Package cnn_win_pkg holds:
  - clog2 helper and PN/WP/HP derivation functions
  - window index function idx(i,j)=i*K+j
- Sub-module win_line_buf: a single-port-read/write RAM of depth WP and width DATA_W, instantiated K-1 times in a cascade.
- All counters and control stay in conv_window_gen.

Test Plan:
- IMG_W=IMG_H=4, K=3, STRIDE=1, PAD_EN=1, pixels 1..16, m_ready=1:
  - Response: 16 windows.
  - First window = {0,0,0, 0,1,2, 0,5,6} with m_first.
  - Last window = {11,12,0, 15,16,0, 0,0,0} with m_last.
  - frame_done pulses once.
- Same geometry, STRIDE=2:
  - Response: 4 windows, centres (0,0),(0,2),(2,0),(2,2).
  - Second window = {0,0,0, 2,3,4, 6,7,8}.
- PAD_EN=0, K=3, 4×4 image:
  - Response: 4 windows.
  - First = {1,2,3, 5,6,7, 9,10,11}; last = {6,7,8, 10,11,12, 14,15,16}.
  - Exactly 16 input beats are accepted.
- m_ready low for 10 cycles mid-frame, random s_valid gaps:
  - m_window and flags stay stable while stalled.
  - s_ready is 0 while stalled; no window is lost or duplicated versus the golden model.
- clr asserted after 7 accepted pixels, then a fresh 1..16 frame:
  - The output matches the clean-frame result from the first test.
  - The beat presented during clr is not consumed.
- rst pulsed mid-frame, then two back-to-back frames:
  - All outputs are 0 during reset.
  - Both frames produce identical 16-window sequences with no idle gap.
